// File: rtl/c_coef_loader.sv
// Streams 3*N/2 coefficient words (C, C+S, C-S per butterfly) into a coefficient bank.
// Optional running checksum of the loaded words is enabled with `define C_LOAD_CHECKSUM_EN.
module c_coef_loader #(
    parameter int N   = 16,
    parameter int MSB = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [MSB-1:0] s_data,
    input  logic           s_valid,
    output logic           s_ready,
    output logic           we,
    output logic [1:0]     count,
    output logic [N/2-1:0] bf_id,
    output logic [MSB-1:0] data,
`ifdef C_LOAD_CHECKSUM_EN
    output logic [MSB-1:0] checksum,
`endif
    output logic           busy,
    output logic           done
);

    localparam int BW = N / 2;
    localparam logic [BW-1:0] LAST_IDX = BW'(N / 2 - 1);
    localparam logic [1:0]    LAST_SEL = 2'd2;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t          state, state_nxt;
    logic [1:0]      sel;
    logic [BW-1:0]   idx;
    logic            accept;
    logic            load_go;
    logic            last_word;

    logic            vld_p1;
    logic [1:0]      count_p1;
    logic [BW-1:0]   bf_id_p1;
    logic [MSB-1:0]  data_p1;

    assign accept    = s_valid && s_ready;
    assign load_go   = (state == IDLE) && start;
    assign last_word = (sel == LAST_SEL) && (idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = LOAD;
            end
            LOAD: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (accept && last_word) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Select is the outer loop, butterfly index the inner one; select wraps to 0 after the final word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel <= 2'd0;
            idx <= '0;
        end else if (load_go) begin
            sel <= 2'd0;
            idx <= '0;
        end else if (accept) begin
            if (idx == LAST_IDX) begin
                idx <= '0;
                sel <= (sel == LAST_SEL) ? 2'd0 : sel + 2'd1;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    // Stage p1: accepted word registered towards the coefficient bank
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            count_p1 <= 2'd0;
            bf_id_p1 <= '0;
            data_p1  <= '0;
        end else begin
            vld_p1 <= accept;
            if (accept) begin
                count_p1 <= sel;
                bf_id_p1 <= idx;
                data_p1  <= s_data;
            end
        end
    end

    assign we    = vld_p1;
    assign count = count_p1;
    assign bf_id = bf_id_p1;
    assign data  = data_p1;

`ifdef C_LOAD_CHECKSUM_EN
    function automatic logic [MSB-1:0] wrap_add(input logic [MSB-1:0] a, input logic [MSB-1:0] b);
        return a + b;
    endfunction

    logic [MSB-1:0] sum_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       sum_p1 <= '0;
        else if (load_go) sum_p1 <= '0;
        else if (accept)  sum_p1 <= wrap_add(sum_p1, s_data);
    end

    assign checksum = sum_p1;
`endif

endmodule

// File: tb/tb_c_coef_loader.sv
// Self-checking bench for c_coef_loader: randomized loads against a write-order reference model.
// Checksum scenario is compiled in when C_LOAD_CHECKSUM_EN is defined.
module tb_c_coef_loader;

    localparam int N    = 16;
    localparam int MSB  = 16;
    localparam int HALF = N / 2;
    localparam int NW   = 3 * HALF;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            start = 1'b0;
    logic [MSB-1:0]  s_data = '0;
    logic            s_valid = 1'b0;
    logic            s_ready;
    logic            we;
    logic [1:0]      count;
    logic [HALF-1:0] bf_id;
    logic [MSB-1:0]  data;
    logic            busy;
    logic            done;
`ifdef C_LOAD_CHECKSUM_EN
    logic [MSB-1:0]  checksum;
    logic [MSB-1:0]  ck_at_done;
`endif

    c_coef_loader #(.N(N), .MSB(MSB)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .we(we), .count(count), .bf_id(bf_id), .data(data),
`ifdef C_LOAD_CHECKSUM_EN
        .checksum(checksum),
`endif
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]      c;
        logic [HALF-1:0] b;
        logic [MSB-1:0]  d;
        logic            dn;
        int              cyc;
    } wr_t;

    wr_t            obs_q[$];
    logic [MSB-1:0] words[$];
    int             checks = 0;
    int             errors = 0;
    int             ncyc = 0;
    int             lat_bad = 0;
    int             done_cnt = 0;
    int             rdy_cnt = 0;
    logic           prev_acc = 1'b0;

    // Observer: logs every write and flags a we that does not follow an acceptance by one cycle.
    always @(negedge clk) begin
        ncyc++;
        if (!rst_n) begin
            prev_acc = 1'b0;
        end else begin
            if (we !== prev_acc) lat_bad++;
            if (done === 1'b1) begin
                done_cnt++;
                if (we !== 1'b1) lat_bad++;
`ifdef C_LOAD_CHECKSUM_EN
                ck_at_done = checksum;
`endif
            end
            if (we === 1'b1) obs_q.push_back('{count, bf_id, data, done, ncyc});
            if (s_ready !== 1'b0) rdy_cnt++;
            prev_acc = s_valid && s_ready;
        end
    end

    task automatic check(input string tag, input logic [63:0] o, input logic [63:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    // vmode: 0 back-to-back, 1 toggling valid, 2 random valid.
    // dmode: 0 words 1..NW, 1 random, 2 all ones. restart_at: word index at which start is re-pulsed.
    task automatic do_load(input int vmode, input int dmode, input int restart_at, input int abort_after);
        int k;
        int cyc;
        logic [MSB-1:0] sum;
        obs_q.delete();
        words.delete();
        sum = '0;
        for (int i = 0; i < NW; i++) begin
            case (dmode)
                0:       words.push_back(MSB'(i + 1));
                1:       words.push_back(MSB'($urandom));
                default: words.push_back({MSB{1'b1}});
            endcase
            sum = sum + words[i];
        end
        done_cnt = 0;
        lat_bad  = 0;
        @(posedge clk); #2;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        check("busy_in_load", {busy, s_ready}, 2'b11);
        k = 0;
        cyc = 0;
        while (k < NW && cyc < 1000) begin
            case (vmode)
                0:       s_valid = 1'b1;
                1:       s_valid = (cyc % 2) == 0;
                default: s_valid = 1'($urandom_range(0, 1));
            endcase
            s_data = s_valid ? words[k] : MSB'($urandom);
            start  = (restart_at >= 0) && (k == restart_at);
            @(negedge clk); #1;
            if (abort_after > 0 && obs_q.size() == abort_after) begin
                rst_n = 1'b0;
                #1;
                check("abort_outputs", {we, count, bf_id, data, done, busy, s_ready}, '0);
                check("abort_nwrites", obs_q.size(), abort_after);
                for (int j = 0; j < obs_q.size(); j++)
                    check("abort_prefix", {obs_q[j].c, obs_q[j].b, obs_q[j].d},
                          {2'(j / HALF), 8'(j % HALF), words[j]});
                s_valid = 1'b0;
                start   = 1'b0;
                return;
            end
            if (s_valid && s_ready) k++;
            @(posedge clk); #2;
            cyc++;
        end
        s_valid = 1'b0;
        start   = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("accepted", k, NW);
        check("nwrites", obs_q.size(), NW);
        for (int j = 0; j < obs_q.size() && j < NW; j++)
            check("write", {obs_q[j].c, obs_q[j].b, obs_q[j].d, obs_q[j].dn},
                  {2'(j / HALF), 8'(j % HALF), words[j], (j == NW - 1)});
        check("done_pulses", done_cnt, 1);
        check("latency", lat_bad, 0);
        if (vmode == 0 && obs_q.size() == NW)
            check("consecutive", obs_q[NW-1].cyc - obs_q[0].cyc, NW - 1);
        check("idle_after", {busy, s_ready, done, we}, 4'b0000);
`ifdef C_LOAD_CHECKSUM_EN
        check("checksum_done", ck_at_done, sum);
        check("checksum_hold", checksum, sum);
        if (dmode == 2) check("checksum_ones", ck_at_done, 16'hFFE8);
`endif
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1;
        check("reset_outputs", {we, count, bf_id, data, done, busy, s_ready}, '0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        // valid without start in IDLE: never ready, never written
        obs_q.delete();
        rdy_cnt = 0;
        lat_bad = 0;
        s_valid = 1'b1;
        s_data  = 16'h1234;
        repeat (50) @(posedge clk);
        #2;
        s_valid = 1'b0;
        check("idle_ready", rdy_cnt, 0);
        check("idle_writes", obs_q.size(), 0);
        check("idle_latency", lat_bad, 0);

        do_load(0, 0, -1, 0);
        do_load(1, 1, -1, 0);
        do_load(2, 1, 9, 0);

        // reset after the fifth write, then verify the loader stays quiet until restarted
        do_load(0, 1, -1, 5);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        obs_q.delete();
        rdy_cnt = 0;
        s_valid = 1'b1;
        repeat (20) @(posedge clk);
        #2;
        s_valid = 1'b0;
        check("post_abort_writes", obs_q.size(), 0);
        check("post_abort_ready", rdy_cnt, 0);
        do_load(0, 1, -1, 0);

        do_load(2, 1, -1, 0);
`ifdef C_LOAD_CHECKSUM_EN
        do_load(0, 2, -1, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
